// File: rtl/student_fir_i2s_tx.sv
// FIR output stage: scale/saturate results, buffer them in a FIFO and serialise them as I2S stereo.
// Optional STUDENT_FIR_I2S_TX_ROUND_EN selects round-half-up instead of floor in the scaler.
module student_fir_i2s_tx #(
   parameter int unsigned IN_WIDTH    = 33,
   parameter int unsigned OUT_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SCLK_DIV    = 4,
   parameter int unsigned SHIFT_WIDTH = 6
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            valid_strobe_in,
   input  logic [IN_WIDTH-1:0]             y_in,
   input  logic [SHIFT_WIDTH-1:0]          shift_i,
   input  logic                            enable_i,
   input  logic                            clear_i,
   output logic                            sclk_o,
   output logic                            lrclk_o,
   output logic                            sd_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
   output logic                            overflow_o,
   output logic                            underflow_o
);

   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned DIV_W  = $clog2(SCLK_DIV);
   localparam int unsigned SLOT_N = 2 * OUT_WIDTH;
   localparam int unsigned SLOT_W = $clog2(SLOT_N);
   localparam int unsigned BIT_W  = $clog2(OUT_WIDTH);
   localparam int unsigned MAX_SH = IN_WIDTH - 1;
   localparam int unsigned EXT_W  = IN_WIDTH + 1;

   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

   // ---------------- ingest: scale and saturate ----------------
   logic [31:0]                w_sh_req;
   logic [31:0]                w_sh;
   logic signed [EXT_W-1:0]    w_ext;
   logic signed [EXT_W-1:0]    w_half;
   logic signed [EXT_W-1:0]    w_rnd;
   logic signed [EXT_W-1:0]    w_shr;
   logic [OUT_WIDTH-1:0]       w_sat;

   assign w_sh_req = 32'(shift_i);
   assign w_sh     = (w_sh_req > MAX_SH) ? MAX_SH : w_sh_req;
   assign w_ext    = {y_in[IN_WIDTH-1], y_in};
`ifdef STUDENT_FIR_I2S_TX_ROUND_EN
   assign w_half   = (w_sh == 32'd0) ? '0 : (EXT_W'(1) << (w_sh - 32'd1));
`else
   assign w_half   = '0;
`endif
   // one guard bit keeps the rounding add from wrapping
   assign w_rnd    = w_ext + w_half;
   assign w_shr    = w_rnd >>> w_sh;

   always_comb begin
      w_sat = w_shr[OUT_WIDTH-1:0];
      if (w_shr > SAT_MAX)
         w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (w_shr < SAT_MIN)
         w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   end

   logic                  r_push_vld;
   logic [OUT_WIDTH-1:0]  r_push_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_push_vld  <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_push_vld <= valid_strobe_in;
         if (valid_strobe_in)
            r_push_data <= w_sat;
      end
   end

   // ---------------- serialiser timing ----------------
   logic [DIV_W-1:0]      r_div;
   logic [SLOT_W-1:0]     r_slot;
   logic                  r_sclk;
   logic                  r_lrclk;
   logic                  r_sd;
   logic                  r_en_q;
   logic [OUT_WIDTH-1:0]  r_shadow;

   logic                  w_sclk_tc;
   logic                  w_fall;
   logic [SLOT_W-1:0]     w_slot_nxt;
   logic [31:0]           w_slot32;
   logic [31:0]           w_idx32;
   logic [BIT_W-1:0]      w_bit_idx;
   logic                  w_sd_nxt;
   logic                  w_lr_nxt;

   assign w_sclk_tc  = enable_i && (r_div == DIV_W'(SCLK_DIV - 1));
   assign w_fall     = w_sclk_tc && r_sclk;
   assign w_slot_nxt = (r_slot == SLOT_W'(SLOT_N - 1)) ? '0 : r_slot + SLOT_W'(1);
   assign w_slot32   = 32'(w_slot_nxt);
   assign w_lr_nxt   = (w_slot32 >= OUT_WIDTH);

   // data lags lrclk by one slot: slot 0 and slot OUT_WIDTH carry an LSB
   always_comb begin
      w_idx32 = 32'd0;
      if ((w_slot32 != 32'd0) && (w_slot32 <= OUT_WIDTH))
         w_idx32 = OUT_WIDTH - w_slot32;
      else if (w_slot32 > OUT_WIDTH)
         w_idx32 = SLOT_N - w_slot32;
   end
   assign w_bit_idx = BIT_W'(w_idx32);

   // ---------------- FIFO control ----------------
   logic [OUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [LVL_W-1:0]      r_count;
   logic                  r_ovf;
   logic                  r_udf;
   logic                  r_armed;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop_req;
   logic                  w_pop;
   logic                  w_push_req;
   logic                  w_push;
   logic                  w_ovf;
   logic                  w_udf;
   logic [OUT_WIDTH-1:0]  w_head;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == LVL_W'(FIFO_DEPTH));
   assign w_pop_req  = w_fall && (w_slot_nxt == SLOT_W'(1));
   assign w_pop      = w_pop_req && !w_empty;
   assign w_push_req = r_push_vld && !clear_i;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf      = w_push_req && w_full && !w_pop;
   assign w_udf      = w_pop_req && w_empty && r_armed;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_sd_nxt   = (w_slot_nxt == SLOT_W'(1)) ? (w_pop && w_head[OUT_WIDTH-1])
                                                   : r_shadow[w_bit_idx];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_div    <= '0;
         r_slot   <= '0;
         r_sclk   <= 1'b0;
         r_lrclk  <= 1'b0;
         r_sd     <= 1'b0;
         r_en_q   <= 1'b0;
         r_shadow <= '0;
      end else begin
         r_en_q <= enable_i;
         if (w_pop_req)
            r_shadow <= w_pop ? w_head : '0;
         if (!enable_i) begin
            r_div   <= '0;
            r_slot  <= '0;
            r_sclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sd    <= 1'b0;
         end else begin
            // frame start: slot 0 replays the held word's LSB
            if (!r_en_q)
               r_sd <= r_shadow[0];
            if (w_sclk_tc) begin
               r_div  <= '0;
               r_sclk <= ~r_sclk;
               if (r_sclk) begin
                  r_slot  <= w_slot_nxt;
                  r_lrclk <= w_lr_nxt;
                  r_sd    <= w_sd_nxt;
               end
            end else begin
               r_div <= r_div + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push)
         r_mem[r_wr_ptr] <= r_push_data;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_armed  <= 1'b0;
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LVL_W'(1);
            2'b01:   r_count <= r_count - LVL_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_ovf)
            r_ovf <= 1'b1;
         if (w_udf)
            r_udf <= 1'b1;
         if (!enable_i)
            r_armed <= 1'b0;
         else if (w_push)
            r_armed <= 1'b1;
      end
   end

   assign sclk_o       = r_sclk;
   assign lrclk_o      = r_lrclk;
   assign sd_o         = r_sd;
   assign fifo_level_o = r_count;
   assign overflow_o   = r_ovf;
   assign underflow_o  = r_udf;

endmodule
